piso_tx: RTL and testbench

//  Parallel-in/serial-out framed transmitter. Return path for the bit-serial SIPO

---
 rtl/piso_tx.sv | 145 ++++++++++++++
 tb/tb_piso_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// piso_tx: framed parallel-in/serial-out transmitter with a one-word holding register.
// Define PISO_TX_PARITY_EN to add an even-parity bit between the data and stop bits.
module piso_tx #(
    parameter int width_p     = 8,
    parameter int stop_bits_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               tick_i,
    output logic               serial_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int               IDX_W     = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(width_p - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
    localparam logic             STOP_LAST = (stop_bits_p > 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef PISO_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t             r_state;
    logic [width_p-1:0] r_hold;
    logic               r_holdEmpty;
    logic [width_p-1:0] r_shift;
    logic [IDX_W-1:0]   r_idx;
    logic               r_stopCnt;
    logic               r_serial;
    logic               r_busy;
    logic               r_done;
    logic               w_lastStop;
    logic               w_load;

    assign w_lastStop = (r_state == S_STOP) && tick_i && (r_stopCnt == STOP_LAST);
    // The hold register drains into the shifter from IDLE, or straight from the last stop tick.
    assign w_load     = !r_holdEmpty && ((r_state == S_IDLE) || w_lastStop);

    assign ready_o  = r_holdEmpty;
    assign serial_o = r_serial;
    assign busy_o   = r_busy;
    assign done_o   = r_done;

    // A drain and an accept can never coincide: a drain needs a full hold, an accept an empty one.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_hold      <= '0;
            r_holdEmpty <= 1'b1;
        end else if (w_load) begin
            r_holdEmpty <= 1'b1;
        end else if (valid_i && r_holdEmpty) begin
            r_hold      <= data_i;
            r_holdEmpty <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_idx     <= '0;
            r_stopCnt <= 1'b0;
            r_serial  <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_shift  <= r_hold;
                        r_state  <= S_START;
                        r_serial <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (tick_i) begin
                        r_state  <= S_DATA;
                        r_idx    <= IDX_TOP;
                        r_serial <= r_shift[IDX_TOP];
                    end
                end
                S_DATA: begin
                    if (tick_i) begin
                        if (r_idx == '0) begin
`ifdef PISO_TX_PARITY_EN
                            r_state  <= S_PARITY;
                            r_serial <= ^r_shift;
`else
                            r_state   <= S_STOP;
                            r_stopCnt <= 1'b0;
                            r_serial  <= 1'b1;
`endif
                        end else begin
                            r_idx    <= r_idx - IDX_ONE;
                            r_serial <= r_shift[r_idx - IDX_ONE];
                        end
                    end
                end
`ifdef PISO_TX_PARITY_EN
                S_PARITY: begin
                    if (tick_i) begin
                        r_state   <= S_STOP;
                        r_stopCnt <= 1'b0;
                        r_serial  <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_lastStop) begin
                        r_done <= 1'b1;
                        if (w_load) begin
                            r_shift  <= r_hold;
                            r_state  <= S_START;
                            r_serial <= 1'b0;
                        end else begin
                            r_state  <= S_IDLE;
                            r_serial <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end else if (tick_i) begin
                        r_stopCnt <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_serial <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: directed and randomized checks of piso_tx against a frame-level line model.
// Honours PISO_TX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_piso_tx;

    localparam int WIDTH = 8;
    localparam int STOP  = 2;
`ifdef PISO_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_LEN = 1 + WIDTH + PAR + STOP;

    logic             clk_i   = 1'b0;
    logic             reset_i = 1'b0;
    logic             valid_i = 1'b0;
    logic             tick_i  = 1'b0;
    logic [WIDTH-1:0] data_i  = '0;
    logic             ready_o;
    logic             serial_o;
    logic             busy_o;
    logic             done_o;

    int   nChecks    = 0;
    int   nFail      = 0;
    int   tickPeriod = 4;
    int   tickCnt    = 0;
    int   gapMode    = 0;
    int   doneCount  = 0;
    int   busyFalls  = 0;
    int   busyCycles = 0;
    logic prevBusy   = 1'b0;
    logic stallSeen  = 1'b0;

    logic             expBits[$];
    logic             gotBits[$];
    logic [WIDTH-1:0] pending[$];

    piso_tx #(.width_p(WIDTH), .stop_bits_p(STOP)) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .tick_i   (tick_i),
        .serial_o (serial_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Line image of one frame: start 0, data MSB first, optional even parity, stop ones.
    task automatic pushFrame(input logic [WIDTH-1:0] w);
        expBits.push_back(1'b0);
        for (int i = WIDTH - 1; i >= 0; i--) expBits.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
        expBits.push_back(^w);
`endif
        for (int s = 0; s < STOP; s++) expBits.push_back(1'b1);
    endtask

    task automatic clearScore();
        expBits.delete();
        gotBits.delete();
        pending.delete();
        doneCount  = 0;
        busyFalls  = 0;
        busyCycles = 0;
        stallSeen  = 1'b0;
        prevBusy   = busy_o;
    endtask

    // One clock: drive inputs at the falling edge, record the line bit each tick ends.
    task automatic applyStimulus();
        if (tickPeriod <= 1) begin
            tick_i = 1'b1;
        end else begin
            tick_i  = (tickCnt == 0);
            tickCnt = (tickCnt + 1) % tickPeriod;
        end
        if (pending.size() > 0 && (gapMode == 0 || $urandom_range(2) != 0)) begin
            valid_i = 1'b1;
            data_i  = pending[0];
        end else begin
            valid_i = 1'b0;
            data_i  = WIDTH'($urandom);
        end
        if (valid_i && ready_o) begin
            pushFrame(data_i);
            void'(pending.pop_front());
        end else if (valid_i) begin
            stallSeen = 1'b1;
        end
        if (busy_o && tick_i) gotBits.push_back(serial_o);
        if (busy_o) busyCycles++;
        if (done_o) doneCount++;
        if (prevBusy && !busy_o) busyFalls++;
        prevBusy = busy_o;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic runTraffic(input string tag, input int maxCycles);
        int n = 0;
        while ((pending.size() > 0 || busy_o || !ready_o) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_timeout"}, 32'(n < maxCycles), 32'd1);
        pending.delete();
        repeat (3) applyStimulus();
    endtask

    task automatic checkFrames(input string tag, input int nFrames);
        int n;
        checkOutput({tag, "_bitcount"}, gotBits.size(), expBits.size());
        n = (gotBits.size() < expBits.size()) ? gotBits.size() : expBits.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s_bit%0d", tag, i), gotBits[i], expBits[i]);
        checkOutput({tag, "_done"}, doneCount, nFrames);
    endtask

    initial begin
        $display("[TB] piso_tx bench, width %0d, %0d stop bits, parity %0d", WIDTH, STOP, PAR);

        // Reset asserted between edges must act at once.
        #3 reset_i = 1'b1;
        #1;
        checkOutput("rst_serial", serial_o, 1);
        checkOutput("rst_ready", ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        clearScore();

        // Single frame of 0xA5, tick every 4 clocks.
        tickPeriod = 4;
        pending.push_back(8'hA5);
        runTraffic("a5", 500);
        checkOutput("a5_frame_len", gotBits.size(), FRAME_LEN);
        checkFrames("a5", 1);
        checkOutput("a5_busy_runs", busyFalls, 1);
        clearScore();

        // Three words with valid held: hold fills mid-frame, third word stalls, no idle gap.
        pending.push_back(8'h3C);
        pending.push_back(8'hFF);
        pending.push_back(8'h5A);
        runTraffic("b2b", 1000);
        checkOutput("b2b_stall", stallSeen, 1);
        checkFrames("b2b", 3);
        checkOutput("b2b_busy_runs", busyFalls, 1);
        clearScore();

`ifdef PISO_TX_PARITY_EN
        pending.push_back(8'h07);
        pending.push_back(8'h00);
        runTraffic("par", 1000);
        checkOutput("par_07", gotBits[1 + WIDTH], 1);
        checkOutput("par_00", gotBits[FRAME_LEN + 1 + WIDTH], 0);
        checkFrames("par", 2);
        clearScore();
`endif

        // Reset during data bit 3 of 0xF0 while 0x11 sits in hold.
        begin
            int n = 0;
            pending.push_back(8'hF0);
            pending.push_back(8'h11);
            while (gotBits.size() < 5 && n < 300) begin
                applyStimulus();
                n++;
            end
            checkOutput("mid_timeout", 32'(n < 300), 32'd1);
            checkOutput("mid_bit3_line", serial_o, 0);
            checkOutput("mid_hold_full", ready_o, 0);
            #2 reset_i = 1'b1;
            #1;
            checkOutput("mid_rst_serial", serial_o, 1);
            checkOutput("mid_rst_ready", ready_o, 1);
            checkOutput("mid_rst_busy", busy_o, 0);
            checkOutput("mid_rst_done", done_o, 0);
            @(negedge clk_i);
            @(negedge clk_i);
            reset_i = 1'b0;
            clearScore();
            tickCnt = 0;
            repeat (20) applyStimulus();
            checkOutput("post_rst_quiet", gotBits.size(), 0);
            checkOutput("post_rst_idle", busy_o, 0);
            pending.push_back(8'h96);
            runTraffic("post_rst", 500);
            checkFrames("post_rst", 1);
            clearScore();
        end

        // Tick tied high: one line bit per clock, back-to-back frames.
        tickPeriod = 1;
        pending.push_back(8'hC3);
        pending.push_back(8'h81);
        pending.push_back(8'h7E);
        runTraffic("tick_high", 500);
        checkFrames("tick_high", 3);
        checkOutput("tick_high_busy_runs", busyFalls, 1);
        checkOutput("tick_high_busy_cycles", busyCycles, 3 * FRAME_LEN);
        clearScore();

        // Random words, random tick rate and producer gaps.
        gapMode = 1;
        for (int r = 0; r < 4; r++) begin
            tickPeriod = $urandom_range(5, 1);
            for (int k = 0; k < 4; k++) pending.push_back(WIDTH'($urandom));
            runTraffic($sformatf("rnd%0d", r), 3000);
            checkFrames($sformatf("rnd%0d", r), 4);
            clearScore();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
